// File: rtl/ex_operand_stage_if.sv
// ID-to-EX instruction bundle: decoded fields and register-file read data
// that the ID stage presents to the operand stage each cycle.
interface ex_operand_stage_if #(
    parameter int XLen         = 32,
    parameter int NOpsWidth    = 3,
    parameter int RegAddrWidth = 5
);
    logic                    id_valid_i;
    logic [XLen-1:0]         id_pc_i;
    logic [RegAddrWidth-1:0] id_rs1_addr_i;
    logic [RegAddrWidth-1:0] id_rs2_addr_i;
    logic                    id_rs1_used_i;
    logic                    id_rs2_used_i;
    logic [XLen-1:0]         id_rs1_data_i;
    logic [XLen-1:0]         id_rs2_data_i;
    logic [XLen-1:0]         id_imm_i;
    logic [RegAddrWidth-1:0] id_rd_addr_i;
    logic                    id_reg_write_i;
    logic                    id_mem_read_i;
    logic [1:0]              id_a_sel_i;
    logic                    id_b_sel_i;
    logic [NOpsWidth-1:0]    id_alu_control_i;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_used_i, id_rs2_used_i, id_rs1_data_i, id_rs2_data_i,
               id_imm_i, id_rd_addr_i, id_reg_write_i, id_mem_read_i,
               id_a_sel_i, id_b_sel_i, id_alu_control_i
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
               id_rs1_used_i, id_rs2_used_i, id_rs1_data_i, id_rs2_data_i,
               id_imm_i, id_rd_addr_i, id_reg_write_i, id_mem_read_i,
               id_a_sel_i, id_b_sel_i, id_alu_control_i
    );
endinterface

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, WB capture bypass,
// load-use hazard detection and ALU operand selection.
module ex_operand_stage #(
    parameter int XLen         = 32,
    parameter int NOps         = 5,
    parameter int RegAddrWidth = 5,
    localparam int NOpsWidth   = $clog2(NOps)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    stall_i,
    ex_operand_stage_if.slave       id_if,
    input  logic                    mem_reg_write_i,
    input  logic [RegAddrWidth-1:0] mem_rd_addr_i,
    input  logic [XLen-1:0]         mem_result_i,
    input  logic                    wb_reg_write_i,
    input  logic [RegAddrWidth-1:0] wb_rd_addr_i,
    input  logic [XLen-1:0]         wb_result_i,
    output logic                    hazard_o,
    output logic                    ex_valid_o,
    output logic [XLen-1:0]         alu_a_o,
    output logic [XLen-1:0]         alu_b_o,
    output logic [NOpsWidth-1:0]    alu_control_o,
    output logic [XLen-1:0]         ex_store_data_o,
    output logic [XLen-1:0]         ex_pc_o,
    output logic [RegAddrWidth-1:0] ex_rd_addr_o,
    output logic                    ex_reg_write_o,
    output logic                    ex_mem_read_o
);

    logic                    r_valid;
    logic [XLen-1:0]         r_pc;
    logic [RegAddrWidth-1:0] r_rs1_addr;
    logic [RegAddrWidth-1:0] r_rs2_addr;
    logic [XLen-1:0]         r_rs1_data;
    logic [XLen-1:0]         r_rs2_data;
    logic [XLen-1:0]         r_imm;
    logic [RegAddrWidth-1:0] r_rd_addr;
    logic                    r_reg_write;
    logic                    r_mem_read;
    logic [1:0]              r_a_sel;
    logic                    r_b_sel;
    logic [NOpsWidth-1:0]    r_alu_control;

    logic                    w_hazard;
    logic                    w_clear;
    logic [XLen-1:0]         w_rs1_fwd;
    logic [XLen-1:0]         w_rs2_fwd;

    // Nonzero-register write match: x0 is never a forwarding source.
    function automatic logic wr_hit(input logic we,
                                    input logic [RegAddrWidth-1:0] rd,
                                    input logic [RegAddrWidth-1:0] rs);
        return we && (rd != {RegAddrWidth{1'b0}}) && (rd == rs);
    endfunction

    // Load-use hazard, suppressed while the stage is stalled or flushed.
    always_comb begin
        w_hazard = 1'b0;
        if (stall_i || flush_i) begin
            w_hazard = 1'b0;
        end else if (r_valid && r_mem_read && (r_rd_addr != {RegAddrWidth{1'b0}}) &&
                     id_if.id_valid_i) begin
            w_hazard = (id_if.id_rs1_used_i && (id_if.id_rs1_addr_i == r_rd_addr)) ||
                       (id_if.id_rs2_used_i && (id_if.id_rs2_addr_i == r_rd_addr));
        end else begin
            w_hazard = 1'b0;
        end
    end

    // Hazard only bubbles when not stalled, so it folds into one clear term.
    assign w_clear = rst_i || flush_i || (!stall_i && w_hazard);

    // Pipeline register: clear, hold with WB refresh, or load with WB bypass.
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_valid       <= 1'b0;
            r_pc          <= {XLen{1'b0}};
            r_rs1_addr    <= {RegAddrWidth{1'b0}};
            r_rs2_addr    <= {RegAddrWidth{1'b0}};
            r_rs1_data    <= {XLen{1'b0}};
            r_rs2_data    <= {XLen{1'b0}};
            r_imm         <= {XLen{1'b0}};
            r_rd_addr     <= {RegAddrWidth{1'b0}};
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_a_sel       <= 2'd0;
            r_b_sel       <= 1'b0;
            r_alu_control <= {NOpsWidth{1'b0}};
        end else if (stall_i) begin
            if (wr_hit(wb_reg_write_i, wb_rd_addr_i, r_rs1_addr)) begin
                r_rs1_data <= wb_result_i;
            end
            if (wr_hit(wb_reg_write_i, wb_rd_addr_i, r_rs2_addr)) begin
                r_rs2_data <= wb_result_i;
            end
        end else begin
            r_valid       <= id_if.id_valid_i;
            r_pc          <= id_if.id_pc_i;
            r_rs1_addr    <= id_if.id_rs1_addr_i;
            r_rs2_addr    <= id_if.id_rs2_addr_i;
            r_rs1_data    <= wr_hit(wb_reg_write_i, wb_rd_addr_i, id_if.id_rs1_addr_i) ?
                             wb_result_i : id_if.id_rs1_data_i;
            r_rs2_data    <= wr_hit(wb_reg_write_i, wb_rd_addr_i, id_if.id_rs2_addr_i) ?
                             wb_result_i : id_if.id_rs2_data_i;
            r_imm         <= id_if.id_imm_i;
            r_rd_addr     <= id_if.id_rd_addr_i;
            r_reg_write   <= id_if.id_reg_write_i && id_if.id_valid_i;
            r_mem_read    <= id_if.id_mem_read_i && id_if.id_valid_i;
            r_a_sel       <= id_if.id_a_sel_i;
            r_b_sel       <= id_if.id_b_sel_i;
            r_alu_control <= id_if.id_alu_control_i;
        end
    end

    // Operand forwarding, MEM before WB before the registered value.
    always_comb begin
        w_rs1_fwd = r_rs1_data;
        w_rs2_fwd = r_rs2_data;
        if (wr_hit(mem_reg_write_i, mem_rd_addr_i, r_rs1_addr)) begin
            w_rs1_fwd = mem_result_i;
        end else if (wr_hit(wb_reg_write_i, wb_rd_addr_i, r_rs1_addr)) begin
            w_rs1_fwd = wb_result_i;
        end else begin
            w_rs1_fwd = r_rs1_data;
        end
        if (wr_hit(mem_reg_write_i, mem_rd_addr_i, r_rs2_addr)) begin
            w_rs2_fwd = mem_result_i;
        end else if (wr_hit(wb_reg_write_i, wb_rd_addr_i, r_rs2_addr)) begin
            w_rs2_fwd = wb_result_i;
        end else begin
            w_rs2_fwd = r_rs2_data;
        end
    end

    // ALU operand muxes.
    always_comb begin
        alu_a_o = {XLen{1'b0}};
        alu_b_o = {XLen{1'b0}};
        case (r_a_sel)
            2'd0:    alu_a_o = w_rs1_fwd;
            2'd1:    alu_a_o = r_pc;
            default: alu_a_o = {XLen{1'b0}};
        endcase
        if (r_b_sel) begin
            alu_b_o = r_imm;
        end else begin
            alu_b_o = w_rs2_fwd;
        end
    end

    assign hazard_o        = w_hazard;
    assign ex_valid_o      = r_valid;
    assign alu_control_o   = r_alu_control;
    assign ex_store_data_o = w_rs2_fwd;
    assign ex_pc_o         = r_pc;
    assign ex_rd_addr_o    = r_rd_addr;
    assign ex_reg_write_o  = r_reg_write && r_valid;
    assign ex_mem_read_o   = r_mem_read && r_valid;

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage placed directly upstream of the ALU.
- Captures decoded instruction fields from ID and resolves RAW hazards by forwarding from MEM and WB.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU operand and control inputs every cycle.

Parameters:
XLen, 32, datapath width; must match the ALU.
NOps, 5, number of ALU operations; NOpsWidth = $clog2(NOps), which is 3 at the default.
RegAddrWidth, 5, register index width.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  squash the instruction entering EX
stall_i  in  1  external stall; hold EX contents
id_valid_i  in  1  ID holds a valid instruction
id_pc_i  in  XLen  instruction PC
id_rs1_addr_i, id_rs2_addr_i  in  RegAddrWidth  source register indices
id_rs1_used_i, id_rs2_used_i  in  1  instruction reads rs1 / rs2
id_rs1_data_i, id_rs2_data_i  in  XLen  register-file read data
id_imm_i  in  XLen  sign-extended immediate
id_rd_addr_i  in  RegAddrWidth  destination register
id_reg_write_i  in  1  instruction writes rd
id_mem_read_i  in  1  instruction is a load
id_a_sel_i  in  2  operand A select: 0 = rs1, 1 = pc, 2 = zero, 3 = zero
id_b_sel_i  in  1  operand B select: 0 = rs2, 1 = imm
id_alu_control_i  in  NOpsWidth  ALU operation code
mem_reg_write_i, mem_rd_addr_i, mem_result_i  in  1/RegAddrWidth/XLen  MEM-stage writeback info
wb_reg_write_i, wb_rd_addr_i, wb_result_i  in  1/RegAddrWidth/XLen  WB-stage writeback info
hazard_o  out  1  load-use hazard; ID must hold
ex_valid_o  out  1  EX holds a valid instruction
alu_a_o, alu_b_o  out  XLen  ALU operands
alu_control_o  out  NOpsWidth  ALU operation code
ex_store_data_o  out  XLen  forwarded rs2 value (store data)
ex_pc_o  out  XLen  registered PC
ex_rd_addr_o  out  RegAddrWidth  registered rd
ex_reg_write_o, ex_mem_read_o  out  1  registered, gated by ex_valid_o

Behaviour:
- Register update priority at posedge clk_i: rst_i > flush_i > stall_i (hold) > hazard_o (bubble) > load.
- Reset, flush and bubble:
  - ex_valid_o, ex_reg_write_o and ex_mem_read_o are set to 0.
  - All data and field registers (pc, rs data/addr, imm, rd, selects, control) are set to 0.
  - Consequently alu_a_o = alu_b_o = 0 and alu_control_o = 0 in the following cycle.
- Load: all id_* fields are captured; ex_valid_o <= id_valid_i.
  - ex_reg_write_o and ex_mem_read_o are ANDed with id_valid_i.
- Capture bypass: when loading, if wb_reg_write_i, wb_rd_addr_i != 0 and wb_rd_addr_i == id_rsN_addr_i, the stage captures wb_result_i instead of id_rsN_data_i.
- Hold refresh: while stall_i holds the stage, a valid WB write matching a held rsN (nonzero) overwrites the held rsN data. This keeps the value valid if WB retires during the stall.
- hazard_o is combinational:
  - Asserted when ex_valid_o & ex_mem_read_o & ex_rd_addr_o != 0 & id_valid_i, and the ID instruction reads that register.
  - "Reads that register" means (id_rs1_used_i & id_rs1_addr_i == ex_rd_addr_o) | (id_rs2_used_i & id_rs2_addr_i == ex_rd_addr_o).
  - hazard_o is forced to 0 while stall_i or flush_i is high.
- EX forwarding is combinational from the registered rsN address/data and the current MEM/WB inputs:
  - Forward from MEM if mem_reg_write_i & mem_rd_addr_i != 0 & match.
  - Otherwise forward from WB if wb_reg_write_i & wb_rd_addr_i != 0 & match.
  - Otherwise use the registered data.
  - MEM has priority over WB. Register x0 never forwards.
- Operand muxes:
  - alu_a_o = forwarded rs1 / ex_pc_o / 0 / 0 for a_sel 0/1/2/3.
  - alu_b_o = forwarded rs2 / imm for b_sel 0/1.
  - ex_store_data_o is always forwarded rs2.
- Latency: one cycle from ID inputs to EX outputs. Forwarding inputs reach the outputs with zero cycles (combinational).
- No arithmetic is performed here; all widths pass through unchanged.

Test Plan:
- Reset: assert rst_i for 2 cycles with random ID inputs -> ex_valid_o = 0, alu_a_o = 0, alu_b_o = 0, ex_reg_write_o = 0, hazard_o = 0.
- Plain load: rs1_data = 0x10, imm = 0x5, a_sel = 0, b_sel = 1, control = 0 -> next cycle alu_a_o = 0x10, alu_b_o = 0x5, alu_control_o = 0, ex_valid_o = 1.
- Forward priority:
  - Held rs1 = x3; mem writes x3 = 0xAA and wb writes x3 = 0xBB -> alu_a_o = 0xAA.
  - Drop mem_reg_write_i -> alu_a_o = 0xBB.
  - Set rd = x0 on both -> alu_a_o = registered data.
- Load-use: EX holds a load to x5; ID reads x5 via rs2 -> hazard_o = 1. Next cycle ex_valid_o = 0 (bubble) and hazard_o = 0.
- Stall refresh: stall_i = 1 with held rs2 = x7; WB writes x7 = 0x1234 one cycle, then idles -> after release, ex_store_data_o = 0x1234.
- Flush vs stall: flush_i = 1 and stall_i = 1 in the same cycle -> ex_valid_o = 0 next cycle. Separately, WB writes x2 = 0x99 in the same cycle ID reads x2 -> captured rs1 = 0x99.
